// File: rtl/display_pkg.sv
// Shared seven-segment display definitions: active-low segment patterns,
// the blank code and the scan-monitor state encoding.
package display_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } scan_state_t;

endpackage

// File: rtl/seven_segment_to_bcd.sv
// Combinational inverse of the BCD-to-seven-segment encoder; blank decodes
// to BCD_BLANK and is legal, every unlisted pattern is illegal.
module seven_segment_to_bcd
    import display_pkg::*;
(
    input  logic [6:0] segment,
    output logic [3:0] bcd,
    output logic       legal
);

    always_comb begin
        bcd   = BCD_BLANK;
        legal = (segment == SEG_BLANK);
        for (int d = 0; d < 10; d++) begin
            if (segment == SEG_DIGIT[d]) begin
                bcd   = 4'(d);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment bus, captures each digit once
// per stable dwell, decodes it back to BCD and reports errors and frame completion.
module seven_segment_scan_decoder
    import display_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [6:0]                    segment,
    input  logic [NUM_DIGITS-1:0]         digit_en_n,
    output logic [4*NUM_DIGITS-1:0]       bcd_out,
    output logic [NUM_DIGITS-1:0]         digit_valid,
    output logic                          frame_valid,
    output logic                          error,
    output logic [$clog2(NUM_DIGITS)-1:0] error_digit
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int SMP_W  = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    scan_state_t           state, state_next;
    logic [CNT_W-1:0]      count, count_next;
    logic [SMP_W-1:0]      sample_in, sample_q;
    logic                  slot_onehot, capture;
    logic [IDX_W-1:0]      slot_idx;
    logic [NUM_DIGITS-1:0] seen, seen_next;
    logic [3:0]            dec_bcd;
    logic                  dec_legal;

    assign sample_in   = {digit_en_n, segment};
    assign slot_onehot = $onehot(~digit_en_n);
    assign seen_next   = seen | (NUM_DIGITS'(1) << slot_idx);

    // The decoder sees the sample being registered, so a one-cycle dwell can
    // capture on the edge that ends its first cycle.
    seven_segment_to_bcd u_decode (
        .segment (segment),
        .bcd     (dec_bcd),
        .legal   (dec_legal)
    );

    always_comb begin
        slot_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!digit_en_n[i]) slot_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        capture    = 1'b0;
        if (!slot_onehot) begin
            state_next = IDLE;
            count_next = '0;
        end else if (sample_in != sample_q) begin
            count_next = CNT_W'(1);
            if (CNT_MAX == CNT_W'(1)) begin
                state_next = HELD;
                capture    = 1'b1;
            end else begin
                state_next = SETTLE;
            end
        end else if (state == SETTLE) begin
            count_next = count + 1'b1;
            if (count_next == CNT_MAX) begin
                state_next = HELD;
                capture    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            sample_q <= '1;
        end else begin
            state    <= state_next;
            count    <= count_next;
            sample_q <= sample_in;
        end
    end

    // An illegal capture still marks the slot as seen, so a frame can complete on it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bcd_out     <= {NUM_DIGITS{BCD_BLANK}};
            digit_valid <= '0;
            frame_valid <= 1'b0;
            error       <= 1'b0;
            error_digit <= '0;
            seen        <= '0;
        end else begin
            frame_valid <= 1'b0;
            error       <= 1'b0;
            if (capture) begin
                if (dec_legal) begin
                    bcd_out[4*slot_idx +: 4] <= dec_bcd;
                    digit_valid[slot_idx]    <= 1'b1;
                end else begin
                    error                 <= 1'b1;
                    error_digit           <= slot_idx;
                    digit_valid[slot_idx] <= 1'b0;
                end
                if (&seen_next) begin
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seen_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed self-checking bench for seven_segment_scan_decoder with
// NUM_DIGITS=4 and STABLE_CYCLES=3.
module tb_seven_segment_scan_decoder;
    import display_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  segment;
    logic [3:0]  digit_en_n;
    logic [15:0] bcd_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        error;
    logic [1:0]  error_digit;

    int check_count = 0;
    int pass_count  = 0;
    int frame_count = 0;
    int error_count = 0;

    seven_segment_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .segment     (segment),
        .digit_en_n  (digit_en_n),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .error       (error),
        .error_digit (error_digit)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && frame_valid) frame_count++;
        if (!reset && error) error_count++;
    end

    task automatic applyStimulus(input logic [3:0] en, input logic [6:0] seg, input int cycles);
        digit_en_n = en;
        segment    = seg;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    initial begin
        reset      = 1'b1;
        digit_en_n = 4'b1111;
        segment    = 7'b1111111;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_bcd", 32'(bcd_out), 32'hFFFF);
        checkOutput("reset_valid", 32'(digit_valid), 32'h0);
        checkOutput("reset_flags", {29'd0, frame_valid, error_digit}, 32'h0);
        reset = 1'b0;

        // Digit 0 shows 2 for exactly three cycles
        applyStimulus(4'b1110, 7'b0100100, 3);
        checkOutput("t1_bcd", 32'(bcd_out), 32'hFFF2);
        checkOutput("t1_valid", 32'(digit_valid), 32'h1);
        checkOutput("t1_error", 32'(error_count), 32'd0);

        // Full scan 1, 9, blank, 8 completes a frame
        applyStimulus(4'b1110, 7'b1111001, 4);
        applyStimulus(4'b1101, 7'b0010000, 4);
        applyStimulus(4'b1011, 7'b1111111, 4);
        checkOutput("t2_no_frame_yet", 32'(frame_count), 32'd0);
        applyStimulus(4'b0111, 7'b0000000, 3);
        checkOutput("t2_frame_pulse", 32'(frame_valid), 32'd1);
        checkOutput("t2_bcd", 32'(bcd_out), 32'h8F91);
        checkOutput("t2_valid", 32'(digit_valid), 32'hF);
        applyStimulus(4'b0111, 7'b0000000, 1);
        checkOutput("t2_frame_drop", 32'(frame_valid), 32'd0);
        checkOutput("t2_frame_count", 32'(frame_count), 32'd1);

        // Illegal pattern on digit 1
        applyStimulus(4'b1101, 7'b0000001, 3);
        checkOutput("t3_error", 32'(error), 32'd1);
        checkOutput("t3_error_digit", 32'(error_digit), 32'd1);
        checkOutput("t3_valid", 32'(digit_valid), 32'hD);
        checkOutput("t3_bcd", 32'(bcd_out), 32'h8F91);
        applyStimulus(4'b1101, 7'b0000001, 1);
        checkOutput("t3_error_once", {31'd0, error}, 32'd0);
        checkOutput("t3_error_count", 32'(error_count), 32'd1);

        // Pattern toggling faster than the dwell never captures
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1011, 7'b0011001, 2);
            applyStimulus(4'b1011, 7'b0110000, 2);
        end
        checkOutput("t4_no_capture", 32'(bcd_out), 32'h8F91);
        checkOutput("t4_no_pulses", 32'(frame_count + error_count), 32'd2);
        applyStimulus(4'b1011, 7'b0011001, 3);
        checkOutput("t4_capture", 32'(bcd_out), 32'h8491);

        // Two enables low is not a scan slot
        applyStimulus(4'b1100, 7'b0000010, 10);
        checkOutput("t5_idle_state", 32'(dut.state), 32'(IDLE));
        checkOutput("t5_idle_bcd", 32'(bcd_out), 32'h8491);
        checkOutput("t5_idle_valid", 32'(digit_valid), 32'hF & 4'b1101);

        // Reset in the middle of a dwell
        applyStimulus(4'b1110, 7'b0000010, 2);
        checkOutput("t5_settle_state", 32'(dut.state), 32'(SETTLE));
        reset = 1'b1;
        #1;
        checkOutput("t5_reset_bcd", 32'(bcd_out), 32'hFFFF);
        checkOutput("t5_reset_valid", 32'(digit_valid), 32'h0);
        checkOutput("t5_reset_flags", {29'd0, frame_valid, error_digit}, 32'h0);
        checkOutput("t5_reset_error", {31'd0, error}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(4'b1110, 7'b0000010, 2);
        checkOutput("t5_post_reset_wait", 32'(bcd_out), 32'hFFFF);
        applyStimulus(4'b1110, 7'b0000010, 1);
        checkOutput("t5_post_reset_capture", 32'(bcd_out), 32'hFFF6);
        checkOutput("t5_post_reset_valid", 32'(digit_valid), 32'h1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
